stage_mem_bus: RTL

Parametrised memory-access pipeline stage that replaces the fixed-latency local SRAM path with a valid/ready request/response bus to an external memory or cache. It sits between the execute and writeback stages. It generates byte strobes and lane-replicated store data, and sign/zero-extends loads. It stalls the pipeline through `mem_ready` for as long as a bus transaction is outstanding, and handles flush while a transaction is in flight.

---
 rtl/stage_mem_bus_pkg.sv | 24 ++
 rtl/stage_mem_bus_lane_align.sv | 62 ++++++
 rtl/stage_mem_bus.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/stage_mem_bus_pkg.sv
// Shared definitions for the memory-access stage: FSM states, exception causes
// and RISC-V funct3 size/sign decode.
package stage_mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  // funct3[1:0] is log2 of the access size; funct3[2] selects zero-extension.
  localparam logic [1:0] F3_SZ_B = 2'd0;
  localparam logic [1:0] F3_SZ_H = 2'd1;
  localparam logic [1:0] F3_SZ_W = 2'd2;
  localparam logic [1:0] F3_SZ_D = 2'd3;
  localparam int         F3_UNSIGNED_BIT = 2;

endpackage

// File: rtl/stage_mem_bus_lane_align.sv
// Combinational lane alignment: store strobes and lane replication, load
// extraction with sign/zero extension. Offsets are rounded down to the size.
module mem_lane_align
  import stage_mem_bus_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]                    st_slog,
  input  logic [$clog2(XLEN/8)-1:0]     st_off,
  input  logic [XLEN-1:0]               st_data,
  output logic [XLEN/8-1:0]             st_strb,
  output logic [XLEN-1:0]               st_lanes,
  input  logic [2:0]                    ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0]     ld_off,
  input  logic [XLEN-1:0]               ld_raw,
  output logic [XLEN-1:0]               ld_data
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  // A doubleword on a 32-bit datapath is faulted upstream; clamp so indexing stays in range.
  function automatic logic [1:0] eff_slog(input logic [1:0] slog);
    if (XLEN == 32 && slog == F3_SZ_D) return F3_SZ_W;
    return slog;
  endfunction

  function automatic logic [OFF_W-1:0] align_down(input logic [OFF_W-1:0] off,
                                                  input logic [1:0] slog);
    logic [OFF_W-1:0] lo;
    lo = OFF_W'((4'd1 << slog) - 4'd1);
    return off & ~lo;
  endfunction

  logic [1:0]       st_es, ld_es;
  logic [3:0]       st_size, ld_size;
  logic [OFF_W-1:0] st_aoff, ld_aoff;
  logic [XLEN-1:0]  ld_shift;
  logic             ld_fill;

  assign st_es   = eff_slog(st_slog);
  assign st_size = 4'd1 << st_es;
  assign st_aoff = align_down(st_off, st_es);

  assign ld_es    = eff_slog(ld_funct3[1:0]);
  assign ld_size  = 4'd1 << ld_es;
  assign ld_aoff  = align_down(ld_off, ld_es);
  assign ld_shift = ld_raw >> {ld_aoff, 3'b000};
  assign ld_fill  = ~ld_funct3[F3_UNSIGNED_BIT] & ld_shift[8*int'(ld_size)-1];

  always_comb begin
    st_strb  = '0;
    st_lanes = '0;
    ld_data  = '0;
    for (int i = 0; i < NB; i++) begin
      st_strb[i] = (i >= int'(st_aoff)) && (i < int'(st_aoff) + int'(st_size));
      st_lanes[8*i +: 8] = st_data[8*(i & (int'(st_size) - 1)) +: 8];
      ld_data[8*i +: 8]  = (i < int'(ld_size)) ? ld_shift[8*i +: 8] : {8{ld_fill}};
    end
  end

endmodule

// File: rtl/stage_mem_bus.sv
// Memory-access pipeline stage bridging execute/writeback to a valid/ready bus.
// Optional feature: define MEM_MISALIGN_EXC_EN to trap misaligned accesses.
module stage_mem_bus
  import stage_mem_bus_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_flush,
  output logic              mem_ready,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              rdata_valid,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_resp_data,
  input  logic              bus_resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_t state, state_nxt;
  logic   kill, accept;

  logic [2:0]       funct3_p0;
  logic [OFF_W-1:0] off_p0;
  logic             write_p0;
  logic [XLEN-1:0]  rdata_p1;
  logic             err_p1;

  logic [OFF_W-1:0] req_off;
  logic             size_fault, misalign, exc_idle;
  logic [3:0]       cause_idle;
  logic [NB-1:0]    st_strb;
  logic [XLEN-1:0]  st_lanes, ld_data;

  assign req_off    = req_addr[OFF_W-1:0];
  assign size_fault = (XLEN == 32) && (req_funct3[1:0] == F3_SZ_D);
`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = |(req_off & OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1));
`else
  assign misalign = 1'b0;
`endif
  assign exc_idle   = size_fault | misalign;
  assign cause_idle = size_fault ? (req_write ? CAUSE_ST_FAULT : CAUSE_LD_FAULT)
                                 : (req_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN);

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .st_slog   (req_funct3[1:0]),
    .st_off    (req_off),
    .st_data   (req_wdata),
    .st_strb   (st_strb),
    .st_lanes  (st_lanes),
    .ld_funct3 (funct3_p0),
    .ld_off    (off_p0),
    .ld_raw    (bus_resp_data),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    mem_ready   = 1'b0;
    rdata_valid = 1'b0;
    exc_valid   = 1'b0;
    exc_cause   = 4'd0;
    unique case (state)
      ST_IDLE: begin
        mem_ready = 1'b1;
        if (req_valid && !mem_flush) begin
          if (exc_idle) begin
            exc_valid = 1'b1;
            exc_cause = cause_idle;
          end else begin
            mem_ready = 1'b0;
            accept    = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ:  if (bus_req_ready)  state_nxt = ST_WAIT;
      ST_WAIT: if (bus_resp_valid) state_nxt = ST_DONE;
      ST_DONE: begin
        mem_ready = 1'b1;
        state_nxt = ST_IDLE;
        if (!kill && !mem_flush) begin
          if (err_p1) begin
            exc_valid = 1'b1;
            exc_cause = write_p0 ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
          end else begin
            rdata_valid = ~write_p0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // p0: request capture at acceptance, bus request held until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      kill          <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_wstrb     <= '0;
      bus_wdata     <= '0;
      bus_addr      <= '0;
      funct3_p0     <= '0;
      off_p0        <= '0;
      write_p0      <= 1'b0;
      rdata_p1      <= '0;
      err_p1        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bus_req_valid <= 1'b1;
        bus_we        <= req_write;
        bus_wstrb     <= st_strb;
        bus_wdata     <= st_lanes;
        bus_addr      <= req_addr & ~ADDR_W'(NB - 1);
        funct3_p0     <= req_funct3;
        off_p0        <= req_off;
        write_p0      <= req_write;
        kill          <= 1'b0;
      end else if (state == ST_REQ && bus_req_ready) begin
        bus_req_valid <= 1'b0;
      end
      // Flush cannot retract an issued request; remember it and drop the result.
      if ((state == ST_REQ || state == ST_WAIT) && mem_flush)
        kill <= 1'b1;
      // p1: response capture
      if (state == ST_WAIT && bus_resp_valid) begin
        rdata_p1 <= ld_data;
        err_p1   <= bus_resp_err;
      end
    end
  end

  assign rdata = rdata_p1;

endmodule
